// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: Moore selects per state, 3-5 cycles per instruction plus one per memory stall.
// Stalls in FETCH/MEMRD/MEMWR while mem_ready_i is low; unsupported encodings park in a sticky TRAP until reset.
module multicycle_controller #(
  parameter bit RESET_STATE_TRAP = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] imm_src_o,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e     state_q, state_d;
  logic [2:0] alu_fn;
  logic       alu_fn_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE_TRAP ? S_TRAP : S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // funct7b5 only selects sub for register-register ops; addi never subtracts.
  always_comb begin
    alu_fn    = ALU_ADD;
    alu_fn_ok = 1'b1;
    case (funct3_i)
      3'b000:  alu_fn = (state_q == S_EXECR && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_write_o   = 1'b0;
    adr_src_o    = 1'b0;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    imm_src_o    = 2'b00;
    alu_ctrl_o   = ALU_ADD;
    illegal_o    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        imm_src_o   = 2'b10;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = (op_i == OP_SW) ? 2'b01 : 2'b00;
        state_d     = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_ctrl_o  = alu_fn;
        state_d     = alu_fn_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_ctrl_o  = ALU_SUB;
        pc_write_o  = zero_i && (funct3_i == 3'b000);
        state_d     = (funct3_i == 3'b000) ? S_FETCH : S_TRAP;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_TRAP: illegal_o = 1'b1;
      default: state_d = S_TRAP;
    endcase

    // Reset overrides everything so an aborted instruction can't write on the reset edge.
    if (rst_i) begin
      pc_write_o   = 1'b0;
      adr_src_o    = 1'b0;
      mem_req_o    = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      result_src_o = 2'b00;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      imm_src_o    = 2'b00;
      alu_ctrl_o   = ALU_ADD;
      illegal_o    = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class with hand-computed states and controls.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst, funct7b5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;
  int wr_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  multicycle_controller dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .mem_ready_i(mem_ready), .pc_write_o(pc_write), .adr_src_o(adr_src),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_write_o(reg_write), .result_src_o(result_src), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .imm_src_o(imm_src), .alu_ctrl_o(alu_ctrl),
    .illegal_o(illegal), .state_o(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0] enables();
    return {pc_write, mem_req, mem_write, ir_write, reg_write};
  endfunction

  initial begin
    rst = 1'b1; mem_ready = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    #2;
    chk("rst_enables", 32'(enables()), 0);
    chk("rst_selects", {alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl}, 0);
    chk("rst_illegal", 32'(illegal), 0);
    step();
    chk("rst_state", 32'(state), 0);
    chk("rst_enables_hold", 32'(enables()), 0);
    step();
    rst = 1'b0;
    #1;
    chk("fetch_state", 32'(state), 0);
    chk("fetch_ctrl", {28'd0, ir_write, pc_write, mem_req, adr_src}, 4'b1110);
    chk("fetch_srcb", 32'(alu_src_b), 2);

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    t0 = cyc;
    step(); chk("r_decode", 32'(state), 1);
    chk("r_decode_sel", {alu_src_a, alu_src_b, imm_src}, 6'b01_01_10);
    step(); chk("r_execr", 32'(state), 6);
    chk("r_alu_sub", 32'(alu_ctrl), 3'b001);
    chk("r_execr_nowr", 32'(reg_write), 0);
    step(); chk("r_aluwb", 32'(state), 8);
    chk("r_aluwb_wr", 32'(reg_write), 1);
    step(); chk("r_back", 32'(state), 0);
    chk("r_latency", cyc - t0, 4);

    // lw with three stall cycles in MEMRD
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    t0 = cyc;
    step(); step();
    chk("lw_memadr", 32'(state), 2);
    chk("lw_imm_i", 32'(imm_src), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk("lw_memrd_state", 32'(state), 3);
      chk("lw_memrd_ctrl", {29'd0, mem_req, adr_src, reg_write}, 3'b110);
      step();
    end
    chk("lw_memwb", 32'(state), 4);
    chk("lw_memwb_ctrl", {29'd0, reg_write, result_src}, 3'b101);
    step(); chk("lw_back", 32'(state), 0);
    chk("lw_latency", cyc - t0, 8);

    // beq taken then not taken
    op = 7'b1100011; funct3 = 3'b000;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      t0 = cyc;
      step(); step();
      chk("beq_state", 32'(state), 9);
      chk("beq_pcw", 32'(pc_write), 32'(z));
      chk("beq_alu", 32'(alu_ctrl), 3'b001);
      step(); chk("beq_back", 32'(state), 0);
      chk("beq_latency", cyc - t0, 3);
    end
    zero = 1'b0;

    // sw with two stall cycles
    op = 7'b0100011; funct3 = 3'b010;
    step(); step();
    chk("sw_imm_s", 32'(imm_src), 1);
    step();
    wr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1;
      chk("sw_memwr_state", 32'(state), 5);
      chk("sw_no_regwr", 32'(reg_write), 0);
      if (mem_write && mem_req) wr_cnt++;
      step();
    end
    chk("sw_write_cycles", wr_cnt, 3);
    chk("sw_back", 32'(state), 0);

    // jal
    op = 7'b1101111;
    step(); step();
    chk("jal_state", 32'(state), 10);
    chk("jal_ctrl", {25'd0, pc_write, alu_src_a, alu_src_b, result_src}, 7'b1_01_10_00);
    step(); chk("jal_aluwb", 32'(state), 8);
    chk("jal_wr", 32'(reg_write), 1);
    step();

    // andi
    op = 7'b0010011; funct3 = 3'b111; funct7b5 = 1'b1;
    step(); step();
    chk("andi_execi", 32'(state), 7);
    chk("andi_ctrl", {alu_src_b, alu_ctrl}, 5'b01_010);
    step(); step();

    // addi with funct7b5 set must still add
    funct3 = 3'b000;
    step(); step();
    chk("addi_add", 32'(alu_ctrl), 3'b000);
    step(); step();

    // unsupported funct3 in EXECI traps without writing
    funct3 = 3'b001;
    step(); step();
    chk("bad_f3_nowr", 32'(reg_write), 0);
    step();
    chk("bad_f3_trap", 32'(state), 15);
    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("bad_f3_recover", 32'(state), 0);

    // beq with funct3 != 000 traps
    op = 7'b1100011; funct3 = 3'b001; zero = 1'b1;
    step(); step();
    chk("bne_nopcw", 32'(pc_write), 0);
    step();
    chk("bne_trap", 32'(state), 15);
    rst = 1'b1; step(); rst = 1'b0; zero = 1'b0; #1;

    // reset in MEMWB suppresses the write
    op = 7'b0000011; funct3 = 3'b010;
    step(); step(); step(); step();
    chk("abort_at_memwb", 32'(state), 4);
    rst = 1'b1; #1;
    chk("abort_no_wr", 32'(reg_write), 0);
    step(); rst = 1'b0; #1;
    chk("abort_state", 32'(state), 0);

    // illegal opcode traps sticky
    op = 7'b1110011; funct3 = 3'b000;
    step(); chk("ill_decode", 32'(state), 1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ill_state", 32'(state), 15);
      chk("ill_flag_enables", {26'd0, illegal, enables()}, 6'b100000);
      step();
    end
    rst = 1'b1; #1;
    chk("ill_rst_flag", 32'(illegal), 0);
    step(); rst = 1'b0; #1;
    chk("ill_recover", 32'(state), 0);
    chk("ill_recover_fetch", {30'd0, ir_write, pc_write}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
